// File: rtl/boot_if.sv
// boot_if: program-loader write channel and instruction-memory port of boot_sequencer.
interface boot_if;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [20:0] ld_data;
    logic        ld_ready;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [20:0] mem_wdata;

    modport master (output ld_valid, ld_addr, ld_data,
                    input  ld_ready, mem_addr, mem_we, mem_wdata);
    modport slave  (input  ld_valid, ld_addr, ld_data,
                    output ld_ready, mem_addr, mem_we, mem_wdata);
endinterface

// File: rtl/boot_sequencer.sv
// boot_sequencer: holds the CPU in reset, lets a loader fill instruction memory, then runs/steps it.
// Define BOOT_SINGLE_STEP_EN to enable the single-cycle STEP state driven by step_req.
module boot_sequencer #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_run_req,
    input  logic        i_halt_req,
    input  logic        i_step_req,
    input  logic        i_restart_req,
    input  logic [7:0]  i_cpu_addr,
    boot_if.slave       bus,
    output logic        o_cpu_en,
    output logic        o_cpu_rst,
    output logic [2:0]  o_state,
    output logic [15:0] o_exec_cnt
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_HALT = 3'd1,
`ifdef BOOT_SINGLE_STEP_EN
        S_STEP = 3'd3,
`endif
        S_RUN  = 3'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

`ifdef BOOT_SINGLE_STEP_EN
    localparam state_t STEP_TGT = S_STEP;
`else
    localparam state_t STEP_TGT = S_HALT;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_hold_cnt;
    logic [3:0]  w_hold_nxt;
    logic        r_cpu_en;
    logic        r_cpu_rst;
    logic        r_ld_ready;
    logic [15:0] r_exec_cnt;
    logic        w_step_go;
    logic        w_next_exec;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef BOOT_SINGLE_STEP_EN
    assign w_step_go   = i_step_req;
    assign w_next_exec = (w_next == S_RUN) || (w_next == S_STEP);
`else
    assign w_step_go   = i_step_req & 1'b0;
    assign w_next_exec = (w_next == S_RUN);
`endif

    // Loader requests take precedence over run/step so a write never races CPU start.
    always_comb begin
        w_next     = r_state;
        w_hold_nxt = '0;
        case (r_state)
            S_HOLD: begin
                if (i_restart_req)
                    w_hold_nxt = '0;
                else if (r_hold_cnt == HOLD_LAST)
                    w_next = S_HALT;
                else
                    w_hold_nxt = r_hold_cnt + 4'd1;
            end
            S_HALT: begin
                if (i_restart_req)
                    w_next = S_HOLD;
                else if (bus.ld_valid)
                    w_next = S_HALT;
                else if (w_step_go)
                    w_next = STEP_TGT;
                else if (i_run_req)
                    w_next = S_RUN;
            end
            S_RUN: begin
                if (i_restart_req)
                    w_next = S_HOLD;
                else if (i_halt_req)
                    w_next = S_HALT;
            end
`ifdef BOOT_SINGLE_STEP_EN
            S_STEP: w_next = i_restart_req ? S_HOLD : S_HALT;
`endif
            default: w_next = S_HOLD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_cpu_rst  <= 1'b1;
            r_cpu_en   <= 1'b0;
            r_ld_ready <= 1'b0;
            r_exec_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= w_hold_nxt;
            r_cpu_rst  <= (w_next == S_HOLD);
            r_cpu_en   <= w_next_exec;
            r_ld_ready <= (w_next == S_HALT);
            if (w_next == S_HOLD && r_state != S_HOLD)
                r_exec_cnt <= '0;
            else if (r_cpu_en)
                r_exec_cnt <= sat_inc(r_exec_cnt);
        end
    end

    assign bus.ld_ready  = r_ld_ready;
    assign bus.mem_we    = bus.ld_valid & r_ld_ready;
    assign bus.mem_wdata = bus.ld_data;
    assign bus.mem_addr  = (r_state == S_HALT && bus.ld_valid) ? bus.ld_addr :
                           (r_state == S_HOLD) ? 8'h00 : i_cpu_addr;

    assign o_cpu_en   = r_cpu_en;
    assign o_cpu_rst  = r_cpu_rst;
    assign o_state    = r_state;
    assign o_exec_cnt = r_exec_cnt;

endmodule
